// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared FSM state, owner encodings and counter width for mem_port_arbiter
package mem_arb_pkg;
  typedef enum logic {IDLE, BUSY} arb_state_t;
  typedef enum logic {OWN_I, OWN_D} owner_t;
  localparam int CNT_W = 4;
endpackage

// File: rtl/mem_arb_pick.sv
// mem_arb_pick: D-priority grant decision with forced I grant once the D streak reaches MAX_D_STREAK; in i_req/d_req/streak, out grant_i/grant_d
module mem_arb_pick
  import mem_arb_pkg::*;
#(
  parameter int MAX_D_STREAK = 3
) (
  input  logic             i_req,
  input  logic             d_req,
  input  logic [CNT_W-1:0] streak,
  output logic             grant_i,
  output logic             grant_d
);
  assign grant_d = d_req && !(i_req && streak == CNT_W'(MAX_D_STREAK));
  assign grant_i = i_req && !grant_d;
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares a fixed-latency single-port memory between fetch (i_*) and data (d_*) requesters, drives mem_*, returns ready/stall; MEM_PORT_ARBITER_PERF_EN adds perf_* counters
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int LATENCY      = 2,
  parameter int MAX_D_STREAK = 3,
  parameter int AW           = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  output logic          i_ready,
  output logic [31:0]   i_rdata,
  output logic          stall_if,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [31:0]   d_wdata,
  output logic          d_ready,
  output logic [31:0]   d_rdata,
  output logic          d_err,
  output logic          stall_mem,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  input  logic [31:0]   mem_rdata,
  input  logic          mem_err
`ifdef MEM_PORT_ARBITER_PERF_EN
  ,
  output logic [31:0]   perf_i_grants,
  output logic [31:0]   perf_d_grants,
  output logic [31:0]   perf_conflict_cycles
`endif
);
  arb_state_t       r_state;
  owner_t           r_owner;
  logic [CNT_W-1:0] r_lat_cnt;
  logic [CNT_W-1:0] r_streak;
  logic [AW-1:0]    r_addr;
  logic             r_we;
  logic [31:0]      r_wdata;
  logic             w_grant_i;
  logic             w_grant_d;
  logic             w_issue;
  logic             w_busy;
  logic             w_done;

  mem_arb_pick #(.MAX_D_STREAK(MAX_D_STREAK)) u_pick (
    .i_req  (i_req),
    .d_req  (d_req),
    .streak (r_streak),
    .grant_i(w_grant_i),
    .grant_d(w_grant_d)
  );

  // rst masks issue and completion so nothing leaks out during the reset cycle
  assign w_issue   = r_state == IDLE && !rst && (w_grant_i || w_grant_d);
  assign w_busy    = r_state == BUSY && !rst;
  assign w_done    = w_busy && r_lat_cnt == CNT_W'(LATENCY);
  assign mem_en    = w_issue;
  assign mem_we    = w_issue ? (w_grant_d && d_we) : (w_busy && r_we);
  assign mem_addr  = w_issue ? (w_grant_d ? d_addr : i_addr) : r_addr;
  assign mem_wdata = w_issue ? (w_grant_d ? d_wdata : '0) : r_wdata;
  assign i_ready   = w_done && r_owner == OWN_I;
  assign d_ready   = w_done && r_owner == OWN_D;
  assign i_rdata   = i_ready ? mem_rdata : '0;
  assign d_rdata   = (d_ready && !r_we) ? mem_rdata : '0;
  assign d_err     = d_ready && mem_err;
  assign stall_if  = i_req && !i_ready;
  assign stall_mem = d_req && !d_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_owner   <= OWN_D;
      r_lat_cnt <= '0;
      r_streak  <= '0;
      r_addr    <= '0;
      r_we      <= 1'b0;
      r_wdata   <= '0;
    end else if (w_issue) begin
      r_state   <= BUSY;
      r_owner   <= w_grant_d ? OWN_D : OWN_I;
      r_lat_cnt <= CNT_W'(1);
      r_addr    <= mem_addr;
      r_we      <= mem_we;
      r_wdata   <= mem_wdata;
      r_streak  <= (w_grant_d && i_req) ? ((r_streak == CNT_W'(MAX_D_STREAK)) ? r_streak : r_streak + CNT_W'(1)) : '0;
    end else if (r_state == BUSY) begin
      r_state   <= w_done ? IDLE : BUSY;
      r_lat_cnt <= w_done ? '0 : r_lat_cnt + CNT_W'(1);
    end
  end

`ifdef MEM_PORT_ARBITER_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_i_grants        <= '0;
      perf_d_grants        <= '0;
      perf_conflict_cycles <= '0;
    end else begin
      perf_i_grants        <= perf_i_grants + {31'd0, w_issue && w_grant_i};
      perf_d_grants        <= perf_d_grants + {31'd0, w_issue && w_grant_d};
      perf_conflict_cycles <= perf_conflict_cycles + {31'd0, i_req && d_req && !i_ready && !d_ready};
    end
  end
`endif
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed literal checks plus randomized traffic checked every cycle against a cycle-number transaction model
module tb_mem_port_arbiter;
  localparam int L = 2;
  localparam int M = 3;
  logic        clk = 0;
  logic        rst = 1;
  logic        i_req = 0;
  logic [31:0] i_addr = 0;
  logic        i_ready;
  logic [31:0] i_rdata;
  logic        stall_if;
  logic        d_req = 0;
  logic        d_we = 0;
  logic [31:0] d_addr = 0;
  logic [31:0] d_wdata = 0;
  logic        d_ready;
  logic [31:0] d_rdata;
  logic        d_err;
  logic        stall_mem;
  logic        mem_en;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = 32'hDEADBEEF;
  logic        mem_err = 0;
`ifdef MEM_PORT_ARBITER_PERF_EN
  logic [31:0] perf_i_grants;
  logic [31:0] perf_d_grants;
  logic [31:0] perf_conflict_cycles;
`endif

  int total = 0;
  int bad = 0;

  mem_port_arbiter #(.LATENCY(L), .MAX_D_STREAK(M), .AW(32)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_ready(i_ready), .i_rdata(i_rdata), .stall_if(stall_if),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_ready(d_ready),
    .d_rdata(d_rdata), .d_err(d_err), .stall_mem(stall_mem),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_err(mem_err)
`ifdef MEM_PORT_ARBITER_PERF_EN
    , .perf_i_grants(perf_i_grants), .perf_d_grants(perf_d_grants),
    .perf_conflict_cycles(perf_conflict_cycles)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %h want %h", n, a, e);
    end
  endtask

  // Transaction model: an access issued in cycle t owns the memory until t+L,
  // completing exactly at t+L; arbitration only happens once the cycle exceeds that.
  int cyc = 0;
  int done_at = -1;
  int streak = 0;
  bit own_d, own_we;
  logic [31:0] own_addr, own_wdata;
  bit e_ir, e_dr;
`ifdef MEM_PORT_ARBITER_PERF_EN
  logic [31:0] m_pi = 0, m_pd = 0, m_pc = 0;
`endif

  always @(negedge clk) begin
    bit e_en, e_we, e_de, chk_a;
    logic [31:0] e_ird, e_drd;
    e_en = 0; e_we = 0; e_de = 0; chk_a = 0; e_ir = 0; e_dr = 0; e_ird = 0; e_drd = 0;
    if (rst) begin
      done_at = -1;
      streak = 0;
    end else if (cyc == done_at) begin
      e_ir  = !own_d;
      e_dr  = own_d;
      e_ird = own_d ? 32'd0 : mem_rdata;
      e_drd = (own_d && !own_we) ? mem_rdata : 32'd0;
      e_de  = own_d && mem_err;
      e_we  = own_we;
      chk_a = 1;
    end else if (cyc < done_at) begin
      e_we  = own_we;
      chk_a = 1;
    end else if (d_req || i_req) begin
      own_d     = d_req && !(i_req && streak >= M);
      own_we    = own_d && d_we;
      own_addr  = own_d ? d_addr : i_addr;
      own_wdata = own_d ? d_wdata : 32'd0;
      streak    = (own_d && i_req) ? streak + 1 : 0;
      done_at   = cyc + L;
      e_en = 1;
      e_we = own_we;
      chk_a = 1;
    end
    chk("mem_en", mem_en, e_en);
    chk("mem_we", mem_we, e_we);
    chk("i_ready", i_ready, e_ir);
    chk("d_ready", d_ready, e_dr);
    chk("i_rdata", i_rdata, e_ird);
    chk("d_rdata", d_rdata, e_drd);
    chk("d_err", d_err, e_de);
    chk("stall_if", stall_if, i_req && !e_ir);
    chk("stall_mem", stall_mem, d_req && !e_dr);
    if (chk_a) begin
      chk("mem_addr", mem_addr, own_addr);
      chk("mem_wdata", mem_wdata, own_wdata);
    end
`ifdef MEM_PORT_ARBITER_PERF_EN
    chk("perf_i", perf_i_grants, m_pi);
    chk("perf_d", perf_d_grants, m_pd);
    chk("perf_c", perf_conflict_cycles, m_pc);
    if (rst) begin
      m_pi = 0; m_pd = 0; m_pc = 0;
    end else begin
      m_pi += {31'd0, e_en && !own_d};
      m_pd += {31'd0, e_en && own_d};
      m_pc += {31'd0, i_req && d_req && !e_ir && !e_dr};
    end
`endif
    cyc++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  initial begin
    int n;
    logic [7:0] ord;
    logic [31:0] pbase;
    repeat (2) step();
    rst = 0;
    at_neg();
    chk("rst_mem_en", mem_en, 0);
    chk("rst_d_ready", d_ready, 0);
    chk("rst_i_rdata", i_rdata, 0);
    // D-only read
    step(); d_req = 1; d_addr = 32'h40;
    at_neg(); chk("t1_en", mem_en, 1); chk("t1_addr", mem_addr, 32'h40); chk("t1_stall", stall_mem, 1);
    step(); at_neg(); chk("t1_en1", mem_en, 0); chk("t1_stall1", stall_mem, 1);
    step(); at_neg(); chk("t1_ready", d_ready, 1); chk("t1_rdata", d_rdata, 32'hDEADBEEF);
    chk("t1_stall2", stall_mem, 0); chk("t1_noissue", mem_en, 0);
    step(); d_addr = 32'h44; at_neg(); chk("t1_reissue", mem_en, 1);
    step(); d_req = 0; step(); step();
    // simultaneous requests from idle
    i_req = 1; i_addr = 32'h100; d_req = 1; d_addr = 32'h80;
    at_neg(); chk("t2_daddr", mem_addr, 32'h80); chk("t2_stall_if", stall_if, 1);
    step(); at_neg(); step(); at_neg(); chk("t2_dready", d_ready, 1);
    step(); d_req = 0; at_neg(); chk("t2_ien", mem_en, 1); chk("t2_iaddr", mem_addr, 32'h100);
    step(); at_neg(); chk("t2_stall4", stall_if, 1);
    step(); at_neg(); chk("t2_iready", i_ready, 1); chk("t2_irdata", i_rdata, 32'hDEADBEEF);
    chk("t2_stall5", stall_if, 0);
    step(); i_req = 0; step();
    // both held: streak forces every fourth grant to I
`ifdef MEM_PORT_ARBITER_PERF_EN
    pbase = perf_i_grants;
`else
    pbase = 0;
`endif
    i_addr = 32'h200; d_addr = 32'h300; i_req = 1; d_req = 1;
    n = 0; ord = 0;
    for (int c = 0; c < 40 && n < 8; c++) begin
      at_neg();
      if (mem_en) begin
        ord = {ord[6:0], mem_addr == 32'h200};
        n++;
      end
      if (n < 8) step();
    end
    chk("t3_count", n, 8);
    chk("t3_order", {24'd0, ord}, 32'h11);
    step(); i_req = 0; d_req = 0; step(); step();
    at_neg();
`ifdef MEM_PORT_ARBITER_PERF_EN
    chk("t3_perf_i", perf_i_grants - pbase, 2);
`endif
    step();
    // D write with error
    d_req = 1; d_we = 1; d_addr = 32'h10; d_wdata = 32'h12345678;
    at_neg(); chk("t4_we", mem_we, 1); chk("t4_wdata", mem_wdata, 32'h12345678);
    step(); at_neg();
    step(); mem_err = 1; mem_rdata = 32'hFFFFFFFF;
    at_neg(); chk("t4_ready", d_ready, 1); chk("t4_err", d_err, 1); chk("t4_rdata", d_rdata, 0);
    step(); d_req = 0; d_we = 0; mem_err = 0; mem_rdata = 32'hDEADBEEF; step();
    // reset during an I access
    i_req = 1; i_addr = 32'h400;
    at_neg(); chk("t5_en", mem_en, 1);
    step(); rst = 1; at_neg();
    step(); rst = 0; i_req = 0; at_neg(); chk("t5_noready", i_ready, 0); chk("t5_noen", mem_en, 0);
    step(); d_req = 1; d_addr = 32'h500;
    at_neg(); chk("t5_den", mem_en, 1); chk("t5_daddr", mem_addr, 32'h500);
    step(); step(); step(); d_req = 0; step();
    // I access with d_we asserted on an idle D port
    i_req = 1; i_addr = 32'h600; d_we = 1;
    at_neg(); chk("t6_en", mem_en, 1); chk("t6_we0", mem_we, 0);
    step(); at_neg(); chk("t6_we1", mem_we, 0);
    step(); at_neg(); chk("t6_we2", mem_we, 0); chk("t6_ready", i_ready, 1);
    step(); i_req = 0; d_we = 0;
    // randomized traffic checked by the model
    for (int k = 0; k < 3000; k++) begin
      step();
      if (!i_req || e_ir) begin
        i_req = 1'($urandom_range(0, 1));
        i_addr = $urandom;
      end
      if (!d_req || e_dr) begin
        d_req = 1'($urandom_range(0, 1));
        d_we = 1'($urandom_range(0, 1));
        d_addr = $urandom;
        d_wdata = $urandom;
      end
      rst = ($urandom_range(0, 99) == 0);
      mem_rdata = $urandom;
      mem_err = 1'($urandom_range(0, 1));
    end
    step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
